// File: rtl/spi_reg_slave.sv
// SPI target for 41-bit bridge frames: oversamples the SPI pins,
// turns each frame into a single register-bus write or read.
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   spi_clk            SPI clock from master (idle low)
//   spi_cs_n           chip select, active low
//   spi_mosi           serial data in, MSB first, sampled on SCLK fall
//   spi_miso           serial read data, updated on SCLK rise
//   reg_addr           register address
//   reg_wdata          register write data
//   reg_wr_en          one-cycle write strobe
//   reg_rd_en          one-cycle read strobe
//   reg_rdata          read data, valid 1 clk after reg_rd_en
//   frame_err          one-cycle pulse on aborted / foreign frame
module spi_reg_slave #(
  parameter logic SLAVE_ID = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [6:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rdata,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sclk_s;
  logic [1:0]  r_mosi_s;
  logic [1:0]  r_cs_s;
  logic        r_sclk_d;
  logic [1:0]  r_flush;
  logic        r_armed;
  logic        r_is_wr;
  logic        r_cap;
  logic [5:0]  r_cnt;
  logic [37:0] r_shift;
  logic [31:0] r_tx;

  logic w_rise;
  logic w_fall;
  logic w_mosi;
  logic w_cs_n;
  logic w_last;
  logic w_tx_win;

  assign w_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_mosi = r_mosi_s[1];
  assign w_cs_n = r_cs_s[1];
  assign w_last = w_fall && (r_cnt == 6'd40);
  assign w_tx_win = (r_cnt >= 6'd9) && (r_cnt <= 6'd40);

  // Pin synchronizers. r_flush marks when the cs_n pipeline
  // holds a real pin value rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s <= 2'b00;
      r_mosi_s <= 2'b00;
      r_cs_s   <= 2'b11;
      r_sclk_d <= 1'b0;
      r_flush  <= 2'b00;
    end else begin
      r_sclk_s <= {r_sclk_s[0], spi_clk};
      r_mosi_s <= {r_mosi_s[0], spi_mosi};
      r_cs_s   <= {r_cs_s[0], spi_cs_n};
      r_sclk_d <= r_sclk_s[1];
      r_flush  <= {r_flush[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_is_wr   <= 1'b0;
      r_cap     <= 1'b0;
      r_cnt     <= 6'd0;
      r_shift   <= '0;
      r_tx      <= '0;
      spi_miso  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      // Register file answers one clk after the read strobe.
      r_cap <= reg_rd_en;
      if (r_cap) r_tx <= reg_rdata;
      // A frame may start only after cs_n was truly seen high.
      if (r_flush[1] && w_cs_n) r_armed <= 1'b1;

      unique case (r_state)
        S_IDLE: begin
          spi_miso <= 1'b0;
          r_cnt    <= 6'd0;
          if (r_armed && !w_cs_n) begin
            r_state <= S_HEADER;
            r_armed <= 1'b0;
            r_shift <= '0;
            r_tx    <= '0;
          end
        end

        S_HEADER: begin
          if (w_cs_n) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_fall) begin
            r_shift <= {r_shift[36:0], w_mosi};
            r_cnt   <= r_cnt + 6'd1;
            if (r_cnt == 6'd8) begin
              // r_shift[7] = wr_rd, r_shift[6] = chip_sel
              if (r_shift[6] != SLAVE_ID) begin
                frame_err <= 1'b1;
                r_state   <= S_IGNORE;
              end else begin
                r_is_wr <= r_shift[7];
                if (!r_shift[7]) begin
                  reg_addr  <= {r_shift[5:0], w_mosi};
                  reg_rd_en <= 1'b1;
                end
                r_state <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          // Final sample beats a simultaneous cs_n release.
          if (w_last) begin
            r_cnt    <= r_cnt + 6'd1;
            spi_miso <= 1'b0;
            if (r_is_wr) begin
              reg_addr  <= r_shift[37:31];
              reg_wdata <= {r_shift[30:0], w_mosi};
              reg_wr_en <= 1'b1;
            end
            r_state <= S_IDLE;
          end else if (w_cs_n) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_fall) begin
            r_shift <= {r_shift[36:0], w_mosi};
            r_cnt   <= r_cnt + 6'd1;
          end else if (w_rise && !r_is_wr && w_tx_win) begin
            spi_miso <= r_tx[31];
            r_tx     <= {r_tx[30:0], 1'b0};
          end
        end

        S_IGNORE: begin
          spi_miso <= 1'b0;
          if (w_cs_n) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: table of frames plus
// hand sequences for reset mid-frame and back-to-back writes.
module tb_spi_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_rdata;
  logic        frame_err;

  always #5 clk = ~clk;

  spi_reg_slave #(.SLAVE_ID(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  // Register file model: data valid one clk after reg_rd_en.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  // Bus monitor.
  int          wr_cnt;
  int          rd_cnt;
  int          err_cnt;
  bit          miso_seen;
  bit          both_seen;
  logic [6:0]  rd_addr;
  logic [38:0] wr_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) begin
        wr_cnt++;
        wr_q.push_back({reg_addr, reg_wdata});
      end
      if (reg_rd_en) begin
        rd_cnt++;
        rd_addr = reg_addr;
      end
      if (frame_err) err_cnt++;
      if (spi_miso) miso_seen = 1'b1;
      if (reg_wr_en && reg_rd_en) both_seen = 1'b1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    wr_cnt = 0;
    rd_cnt = 0;
    err_cnt = 0;
    miso_seen = 1'b0;
    both_seen = 1'b0;
    rd_addr = 7'h00;
    wr_q.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period: MOSI changes with the rise, master samples
  // MISO just before the fall.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    spi_clk = 1'b1;
    wait_clk(4);
    m = spi_miso;
    spi_clk = 1'b0;
    wait_clk(4);
  endtask

  task automatic run_frame(input logic [40:0] f,
                           input int nbits,
                           output logic [31:0] rx);
    logic m;
    rx = '0;
    spi_cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(f[40-i], m);
      if (i >= 9) rx = {rx[30:0], m};
    end
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  typedef struct {
    string       nm;
    logic [40:0] frame;
    int          nbits;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic [6:0]  exp_addr;
    logic [31:0] exp_data;
    bit          chk_rx;
    bit          quiet;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rx;
    logic [40:0] fr;
    logic        m;

    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[7'h12] = 32'hA5A5_3C3C;
    mem[7'h7F] = 32'h8000_0001;
    mem[7'h00] = 32'h0F1E_2D3C;
    clr_mon();

    vecs[0] = '{"wr05", {1'b1, 1'b0, 7'h05, 32'hDEADBEEF}, 41,
                1, 0, 0, 7'h05, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[1] = '{"rd12", {1'b0, 1'b0, 7'h12, 32'h0}, 41,
                0, 1, 0, 7'h12, 32'hA5A53C3C, 1'b1, 1'b0};
    vecs[2] = '{"badid_wr", {1'b1, 1'b1, 7'h33, 32'hCAFEF00D}, 41,
                0, 0, 1, 7'h00, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{"badid_rd", {1'b0, 1'b1, 7'h12, 32'h0}, 41,
                0, 0, 1, 7'h00, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{"abort_wr20", {1'b1, 1'b0, 7'h44, 32'h12345678}, 20,
                0, 0, 1, 7'h00, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{"wr7f", {1'b1, 1'b0, 7'h7F, 32'h1}, 41,
                1, 0, 0, 7'h7F, 32'h1, 1'b0, 1'b1};
    vecs[6] = '{"rd7f", {1'b0, 1'b0, 7'h7F, 32'h0}, 41,
                0, 1, 0, 7'h7F, 32'h80000001, 1'b1, 1'b0};
    vecs[7] = '{"abort_rd10", {1'b0, 1'b0, 7'h12, 32'h0}, 10,
                0, 1, 1, 7'h12, 32'h0, 1'b0, 1'b0};

    // Reset state.
    wait_clk(3);
    chk("rst_miso", spi_miso, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_err", frame_err, 0);
    rst_n = 1'b1;
    wait_clk(8);

    for (int i = 0; i < 8; i++) begin
      clr_mon();
      run_frame(vecs[i].frame, vecs[i].nbits, rx);
      chk({vecs[i].nm, "_wr_cnt"}, wr_cnt, vecs[i].exp_wr);
      chk({vecs[i].nm, "_rd_cnt"}, rd_cnt, vecs[i].exp_rd);
      chk({vecs[i].nm, "_err_cnt"}, err_cnt, vecs[i].exp_err);
      chk({vecs[i].nm, "_wr_rd_same"}, both_seen, 0);
      if (vecs[i].exp_wr != 0 && wr_q.size() > 0) begin
        chk({vecs[i].nm, "_wr_addr"}, wr_q[0][38:32],
            vecs[i].exp_addr);
        chk({vecs[i].nm, "_wr_data"}, wr_q[0][31:0],
            vecs[i].exp_data);
      end
      if (vecs[i].exp_rd != 0)
        chk({vecs[i].nm, "_rd_addr"}, rd_addr, vecs[i].exp_addr);
      if (vecs[i].chk_rx)
        chk({vecs[i].nm, "_rx"}, rx, vecs[i].exp_data);
      if (vecs[i].quiet)
        chk({vecs[i].nm, "_miso_quiet"}, miso_seen, 0);
    end

    // Reset during the data phase of a read of 7'h12.
    clr_mon();
    fr = {1'b0, 1'b0, 7'h12, 32'h0};
    spi_cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 11; i++) spi_bit(fr[40-i], m);
    spi_mosi = fr[29];
    spi_clk = 1'b1;
    wait_clk(4);
    // bit 29 of A5A53C3C is 1
    chk("pre_rst_miso", spi_miso, 1);
    chk("pre_rst_addr", reg_addr, 7'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", spi_miso, 0);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_strobes",
        {reg_wdata, reg_wr_en, reg_rd_en, frame_err}, 0);
    spi_clk = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    clr_mon();
    for (int i = 12; i < 41; i++) spi_bit(fr[40-i], m);
    spi_cs_n = 1'b1;
    wait_clk(8);
    chk("post_rst_no_strobe", wr_cnt + rd_cnt + err_cnt, 0);
    chk("post_rst_miso_quiet", miso_seen, 0);
    clr_mon();
    run_frame({1'b0, 1'b0, 7'h00, 32'h0}, 41, rx);
    chk("rd00_rd_cnt", rd_cnt, 1);
    chk("rd00_rd_addr", rd_addr, 7'h00);
    chk("rd00_rx", rx, 32'h0F1E2D3C);
    chk("rd00_wr_cnt", wr_cnt, 0);

    // Back-to-back writes, one SCLK of cs_n high between.
    clr_mon();
    run_frame({1'b1, 1'b0, 7'h01, 32'h11111111}, 41, rx);
    run_frame({1'b1, 1'b0, 7'h02, 32'h22222222}, 41, rx);
    chk("b2b_wr_cnt", wr_q.size(), 2);
    if (wr_q.size() >= 2) begin
      chk("b2b_first", wr_q[0], {7'h01, 32'h11111111});
      chk("b2b_second", wr_q[1], {7'h02, 32'h22222222});
    end
    chk("b2b_err", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
